// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 block sequencer.
//   SHA256_IV   : initial chaining value H0..H7, with H0 in the top word.
//   seq_state_e : sequencer FSM states.
//   DIGEST_W / BLOCK_W : digest and block widths in bits.
package sha256_pkg;

    localparam int DIGEST_W = 256;
    localparam int BLOCK_W  = 512;

    localparam logic [DIGEST_W-1:0] SHA256_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_OUT   = 3'd3,
        ST_ERROR = 3'd4
    } seq_state_e;

endpackage

// File: rtl/sha256_watchdog.sv
// Cycle watchdog for the compression core.
//   clk, reset : clock and synchronous active-high reset.
//   clear      : forces the count back to zero (takes priority over enable).
//   enable     : counts one cycle per clock while high.
//   expired    : high in the LIMIT-th enabled cycle since the last clear.
module sha256_watchdog #(
    parameter int LIMIT = 100,
    parameter int WIDTH = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and park at the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST_CNT)) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count started at 0, so LAST_CNT marks the LIMIT-th waited cycle.
    assign expired = enable && (cnt_q == LAST_CNT);

endmodule

// File: rtl/sha256_block_sequencer.sv
// Runs a single-block SHA-256 compression core across multi-block messages.
//   in_*        : 512-bit padded block input, valid/ready, with first/last flags.
//   core_*      : drive and observe the external compression core.
//                 core_reset is high except while a block is running.
//   digest_*    : final message digest, valid/ready.
//   blk_count   : blocks completed since the last in_first (saturating).
//   err         : sticky watchdog error; cleared only by reset.
module sha256_block_sequencer
    import sha256_pkg::*;
#(
    parameter int WDOG_LIMIT = 100,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLOCK_W-1:0]  in_block,
    input  logic                in_first,
    input  logic                in_last,
    output logic                core_reset,
    output logic [BLOCK_W-1:0]  core_chunk,
    output logic [DIGEST_W-1:0] core_h,
    input  logic [DIGEST_W-1:0] core_digest,
    input  logic                core_done,
    output logic                digest_valid,
    input  logic                digest_ready,
    output logic [DIGEST_W-1:0] digest,
    output logic [CNT_W-1:0]    blk_count,
    output logic                err
);

    seq_state_e          state_q, state_d;
    logic [DIGEST_W-1:0] h_q, h_d;
    logic [BLOCK_W-1:0]  chunk_q, chunk_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    blk_count_q, blk_count_d;
    logic                core_reset_q, core_reset_d;
    logic                digest_valid_q, digest_valid_d;
    logic                err_q, err_d;
    logic                wdog_expired;

    sha256_watchdog #(
        .LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != ST_RUN),
        .enable  (state_q == ST_RUN),
        .expired (wdog_expired)
    );

    // Next-state and datapath updates; registered outputs follow the next state.
    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        chunk_d     = chunk_q;
        last_d      = last_q;
        blk_count_d = blk_count_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    chunk_d = in_block;
                    last_d  = in_last;
                    if (in_first) begin
                        h_d         = SHA256_IV;
                        blk_count_d = '0;
                    end else begin
                        h_d         = h_q;
                        blk_count_d = blk_count_q;
                    end
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // A result in the same cycle the watchdog fires still counts.
                if (core_done) begin
                    h_d = core_digest;
                    if (blk_count_q != {CNT_W{1'b1}}) begin
                        blk_count_d = blk_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        blk_count_d = blk_count_q;
                    end
                    state_d = last_q ? ST_OUT : ST_IDLE;
                end else if (wdog_expired) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_OUT: begin
                if (digest_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Core stays in reset everywhere but RUN, so it starts fresh on RUN entry.
        core_reset_d   = (state_d != ST_RUN);
        digest_valid_d = (state_d == ST_OUT);
        err_d          = (state_d == ST_ERROR);
    end

    // State, chaining value, block register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            h_q            <= SHA256_IV;
            chunk_q        <= '0;
            last_q         <= 1'b0;
            blk_count_q    <= '0;
            core_reset_q   <= 1'b1;
            digest_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            h_q            <= h_d;
            chunk_q        <= chunk_d;
            last_q         <= last_d;
            blk_count_q    <= blk_count_d;
            core_reset_q   <= core_reset_d;
            digest_valid_q <= digest_valid_d;
            err_q          <= err_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign core_reset   = core_reset_q;
    assign core_chunk   = chunk_q;
    assign core_h       = h_q;
    assign digest_valid = digest_valid_q;
    assign digest       = h_q;
    assign blk_count    = blk_count_q;
    assign err          = err_q;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Self-checking bench for sha256_block_sequencer: behavioural 66-cycle core,
// SHA-256 reference model, scoreboard queue and an independent output monitor.
module tb_sha256_block_sequencer;

    localparam int WDOG_LIMIT = 100;
    localparam int CNT_W      = 16;
    localparam logic [255:0] IV  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_first, in_last;
    logic [511:0] in_block;
    logic         core_reset, core_done;
    logic [511:0] core_chunk;
    logic [255:0] core_h, core_digest, digest;
    logic         digest_valid, digest_ready, err;
    logic [15:0]  blk_count;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [255:0] dig; logic [15:0] cnt; } exp_t;
    exp_t sb[$];

    logic [255:0] model_h;
    logic [15:0]  model_cnt;
    int           ready_mode;

    // behavioural core
    int           core_cyc;
    logic [255:0] core_res;
    logic         core_hang, core_force;
    logic [255:0] core_junk;

    always #5 clk = ~clk;

    sha256_block_sequencer #(.WDOG_LIMIT(WDOG_LIMIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .in_first(in_first), .in_last(in_last),
        .core_reset(core_reset), .core_chunk(core_chunk), .core_h(core_h),
        .core_digest(core_digest), .core_done(core_done),
        .digest_valid(digest_valid), .digest_ready(digest_ready), .digest(digest),
        .blk_count(blk_count), .err(err));

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
                e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   hh + hin[31:0]};
    endfunction

    // Core: loads on its first cycle out of reset, reports 66 cycles later.
    always @(posedge clk) begin
        if (core_reset) begin
            core_cyc <= 0;
        end else begin
            if (core_cyc == 0) core_res <= sha_compress(core_h, core_chunk);
            if (core_cyc < 66) core_cyc <= core_cyc + 1;
        end
    end
    assign core_done   = core_force || (!core_reset && !core_hang && core_cyc == 66);
    assign core_digest = core_force ? core_junk : core_res;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every digest handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && digest_valid && digest_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_digest", 512'(digest), 512'(0));
                if (digest == 256'h0) check("unexpected_digest", 512'd1, 512'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("digest", 512'(digest), 512'(e.dig));
                check("blk_count", 512'(blk_count), 512'(e.cnt));
            end
        end
    end

    // digest_ready driver: 0 = hold low, 1 = hold high, 2 = random.
    initial begin
        digest_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       digest_ready = 1'b0;
                1:       digest_ready = 1'b1;
                default: digest_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // mode: 0 push model result, 1 push known answer, 2 push nothing
    task automatic send_block(input logic [511:0] blk, input logic first, input logic last,
                              input int mode, input logic [255:0] kat);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; in_block = blk; in_first = first; in_last = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 2000) begin @(negedge clk); n++; end
        check("accept_timeout", 512'(in_ready), 512'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (first) begin model_h = IV; model_cnt = '0; end
        model_h = sha_compress(model_h, blk);
        if (model_cnt != 16'hffff) model_cnt = model_cnt + 16'd1;
        if (last && mode == 0) sb.push_back('{model_h, model_cnt});
        if (last && mode == 1) sb.push_back('{kat, model_cnt});
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_h = IV; model_cnt = '0;
        sb.delete();
    endtask

    task automatic wait_sb_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin @(negedge clk); n++; end
        check("scoreboard_drain", 512'(sb.size()), 512'd0);
        @(negedge clk);
        while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [511:0] abc_blk, two1, two2, rblk;
        logic         rf, rl, bad;
        int           k;
        abc_blk = {32'h61626380, 448'h0, 32'h00000018};
        two1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
                32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        two2 = {480'h0, 32'h000001c0};
        reset = 1'b1; in_valid = 1'b0; in_block = '0; in_first = 1'b0; in_last = 1'b0;
        ready_mode = 1; core_hang = 1'b0; core_force = 1'b0; core_junk = {8{32'hdeadbeef}};
        do_reset();

        // reset state
        @(negedge clk);
        check("rst_in_ready", 512'(in_ready), 512'd1);
        check("rst_digest_valid", 512'(digest_valid), 512'd0);
        check("rst_core_reset", 512'(core_reset), 512'd1);
        check("rst_err", 512'(err), 512'd0);
        check("rst_blk_count", 512'(blk_count), 512'd0);
        check("rst_core_h", 512'(core_h), 512'(IV));
        check("rst_core_chunk", core_chunk, 512'd0);

        // abc single block, digest_valid first seen at T+69
        send_block(abc_blk, 1'b1, 1'b1, 1, ABC);
        k = 1; @(negedge clk);
        while (!digest_valid && k < 200) begin @(negedge clk); k++; end
        check("abc_latency", 512'(k), 512'd69);
        check("abc_blk_count", 512'(blk_count), 512'd1);
        wait_sb_empty();

        // core_done while idle is ignored
        core_force = 1'b1;
        repeat (3) @(negedge clk);
        core_force = 1'b0;
        @(negedge clk);
        check("idle_done_h", 512'(core_h), 512'(ABC));
        check("idle_done_cnt", 512'(blk_count), 512'd1);
        check("idle_done_ready", 512'(in_ready), 512'd1);
        check("idle_done_valid", 512'(digest_valid), 512'd0);

        // two-block message, no digest after block 1
        send_block(two1, 1'b1, 1'b0, 1, TWO);
        bad = 1'b0; k = 0;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            if (digest_valid) bad = 1'b1;
            @(negedge clk); k++;
        end
        check("two_mid_digest_valid", 512'(bad), 512'd0);
        send_block(two2, 1'b0, 1'b1, 1, TWO);
        wait_sb_empty();

        // back-pressure
        ready_mode = 0;
        send_block(abc_blk, 1'b1, 1'b1, 1, ABC);
        k = 0; @(negedge clk);
        while (!digest_valid && k < 200) begin @(negedge clk); k++; end
        for (int i = 0; i < 20; i++) begin
            check("bp_digest", 512'(digest), 512'(ABC));
            check("bp_in_ready", 512'(in_ready), 512'd0);
            check("bp_valid", 512'(digest_valid), 512'd1);
            @(negedge clk);
        end
        ready_mode = 1;
        k = 0;
        while (!(digest_ready && digest_valid) && k < 10) begin @(negedge clk); k++; end
        @(negedge clk);
        check("bp_release_idle", 512'(in_ready), 512'd1);
        check("bp_release_valid", 512'(digest_valid), 512'd0);
        check("bp_sb_empty", 512'(sb.size()), 512'd0);

        // reset during RUN cycle 30 (continuation block, H != IV)
        send_block(two2, 1'b0, 1'b1, 2, '0);
        for (int i = 1; i <= 32; i++) @(negedge clk);
        check("abort_in_run", 512'(core_reset), 512'd0);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("abort_idle", 512'(in_ready), 512'd1);
        check("abort_h_iv", 512'(core_h), 512'(IV));
        check("abort_core_reset", 512'(core_reset), 512'd1);
        check("abort_valid", 512'(digest_valid), 512'd0);
        check("abort_cnt", 512'(blk_count), 512'd0);
        send_block(abc_blk, 1'b1, 1'b1, 1, ABC);
        wait_sb_empty();

        // hung core -> watchdog
        core_hang = 1'b1;
        send_block(abc_blk, 1'b1, 1'b1, 2, '0);
        for (int i = 1; i <= WDOG_LIMIT + 2; i++) begin
            @(negedge clk);
            if (i == WDOG_LIMIT + 1) check("wdog_err_early", 512'(err), 512'd0);
            if (i == WDOG_LIMIT + 2) check("wdog_err", 512'(err), 512'd1);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (in_ready || digest_valid || !err) bad = 1'b1;
            @(negedge clk);
        end
        check("wdog_stuck", 512'(bad), 512'd0);
        core_hang = 1'b0;
        do_reset();
        @(negedge clk);
        check("wdog_cleared_err", 512'(err), 512'd0);
        check("wdog_cleared_ready", 512'(in_ready), 512'd1);

        // randomized messages with random back-pressure
        ready_mode = 2;
        for (int i = 0; i < 12; i++) begin
            for (int w = 0; w < 16; w++) rblk[511-32*w -: 32] = $urandom;
            rf = (i == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
            rl = (i == 11) ? 1'b1 : ($urandom_range(0, 2) == 0);
            send_block(rblk, rf, rl, 0, '0);
        end
        wait_sb_empty();
        ready_mode = 1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_block_sequencer.md
# sha256_block_sequencer

Sequences the team's single-block SHA-256 compression core across multi-block messages. Accepts 512-bit padded blocks over a valid/ready handshake and owns the 256-bit chaining value. Each block is run by pulsing the core's reset, holding chunk and chaining inputs stable, and folding the core's digest back into the chaining value. Emits the final message digest on a valid/ready output, and has a watchdog against a hung core.

## Interface
Parameters:
- WDOG_LIMIT, 100: maximum RUN cycles to wait for core_done before error.
- CNT_W, 16: width of the block counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  a padded block is offered.
- in_ready  out  1  the block is accepted on in_valid && in_ready.
- in_block  in  512  block data, word 0 in [511:480].
- in_first  in  1  the block starts a new message; the chaining value is reloaded with the IV.
- in_last  in  1  the block ends the message; the digest is emitted.
- core_reset  out  1  drives the core's reset.
- core_chunk  out  512  drives the core's chunk input.
- core_h  out  256  chaining value to the core, h0 in [255:224].
- core_digest  in  256  core result, already including the chaining add.
- core_done  in  1  core result is valid.
- digest_valid  out  1  the final digest is available.
- digest_ready  in  1  the digest is consumed on digest_valid && digest_ready.
- digest  out  256  the final message digest.
- blk_count  out  CNT_W  blocks completed since the last in_first; saturates at all-ones.
- err  out  1  sticky watchdog error.

## Operation
States: IDLE, START, RUN, OUT, ERROR.
- IDLE:
  - in_ready=1.
  - On accept: latch in_block into the chunk register, latch in_last into last_q.
  - If in_first: H<=IV and blk_count<=0.
  - Go to START.
- START: one cycle, core_reset=1, then go to RUN.
- RUN:
  - core_reset=0; the chunk register and H are held stable; the watchdog counts up from 0.
  - On core_done: H<=core_digest and blk_count increments (saturating).
  - Then go to OUT if last_q, else go to IDLE.
- OUT:
  - digest_valid=1, digest=H.
  - On digest_ready: go to IDLE. H keeps the final value.
- ERROR:
  - Entered when the watchdog reaches WDOG_LIMIT in RUN without core_done.
  - err=1; in_ready=0 and digest_valid=0 until reset.
- core_reset=1 in every state except RUN, so the core is held quiescent and core_done=0 on RUN entry.
- IV (H0..H7): 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- A block with in_first=0 after a completed message continues from the current H. This is legal and not flagged.
- A block with in_first=1 and in_last=1 is a single-block message.

## Timing
- Reset values:
  - state=IDLE, H=IV, chunk register=0, last_q=0, blk_count=0, err=0.
  - Outputs: in_ready=1 (combinational from IDLE), digest_valid=0, core_reset=1.
- Block accepted at cycle T:
  - START in T+1.
  - RUN from T+2; the core loads in T+2.
  - With the team's core, core_done is first seen in T+68 (66 cycles after RUN entry).
  - H is updated at the end of T+68; digest_valid is high from T+69.
- Throughput: 69 cycles per block when in_valid is held high continuously.
- digest_valid and digest hold stable until digest_ready. There is no combinational path from digest_ready to in_ready in the same cycle.
- core_done outside RUN is ignored.
- A reset asserted in any state aborts the current operation in the next cycle and returns all registers to their reset values.

## Structure
- Shared package sha256_pkg:
  - the IV constant (256-bit);
  - a state enum typedef;
  - the DIGEST_W=256 and BLOCK_W=512 constants.
- One sub-module, sha256_watchdog: a counter with clear/enable inputs and an expired output.
- The compressor core is instantiated by the parent, not inside this block.

## Test plan
- "abc" single block (61626380…00000018, in_first=1, in_last=1) with the real core -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad at T+69; blk_count=1.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - digest_valid stays 0 after block 1;
  - final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1;
  - blk_count=2.
- Back-pressure: hold digest_ready=0 for 20 cycles -> digest stable, in_ready=0; digest_ready=1 -> IDLE next cycle.
- Stub core that never asserts core_done -> err=1 WDOG_LIMIT cycles after RUN entry; in_ready stays 0 until reset.
- Reset asserted at RUN cycle 30 -> next cycle: IDLE, H=IV, core_reset=1, digest_valid=0; a following "abc" block gives the correct digest.
- core_done pulsed in IDLE by a stub -> no change to H, blk_count or state.
